// File: rtl/alu_exec_unit.sv
// Registered, handshaked integer execution unit sitting between the RS issue
// port and the CDB arbiter. Simple ops complete in one cycle; the optional
// M-extension adds a fixed-latency multiplier and a radix-2 restoring divider.
//
// state | meaning
// IDLE  | no work held, ready for a new op
// MUL   | multiply result computed, waiting out the configured latency
// DIV   | divider iterating, one quotient bit per cycle
// DONE  | result held on out_* until the CDB grants it
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       inst_name,
    input  logic [XLEN-1:0]  V1,
    input  logic [XLEN-1:0]  V2,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_target_pc,
    output logic             out_jump,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int  SH_W  = $clog2(XLEN);
    localparam int  CNT_W = $clog2(XLEN + MUL_LAT) + 1;
    localparam bit  M_ON  = (ENABLE_M != 0);

    localparam logic [5:0] OP_NOP = 6'd0,  OP_LUI = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL = 6'd3;
    localparam logic [5:0] OP_JALR = 6'd4, OP_BEQ = 6'd5,  OP_BNE = 6'd6,    OP_BLT = 6'd7;
    localparam logic [5:0] OP_BGE = 6'd8,  OP_BLTU = 6'd9, OP_BGEU = 6'd10,  OP_ADDI = 6'd11;
    localparam logic [5:0] OP_SLTI = 6'd12, OP_SLTIU = 6'd13, OP_XORI = 6'd14, OP_ORI = 6'd15;
    localparam logic [5:0] OP_ANDI = 6'd16, OP_SLLI = 6'd17, OP_SRLI = 6'd18, OP_SRAI = 6'd19;
    localparam logic [5:0] OP_ADD = 6'd20, OP_SUB = 6'd21, OP_SLL = 6'd22, OP_SLT = 6'd23;
    localparam logic [5:0] OP_SLTU = 6'd24, OP_XOR = 6'd25, OP_SRL = 6'd26, OP_SRA = 6'd27;
    localparam logic [5:0] OP_OR = 6'd28, OP_AND = 6'd29, OP_MUL = 6'd30, OP_MULH = 6'd31;
    localparam logic [5:0] OP_MULHSU = 6'd32, OP_MULHU = 6'd33, OP_DIV = 6'd34, OP_DIVU = 6'd35;
    localparam logic [5:0] OP_REM = 6'd36, OP_REMU = 6'd37;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d, tgt_q, tgt_d;
    logic              jump_q, jump_d, ill_q, ill_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   dq_q, dq_d, dr_q, dr_d, dd_q, dd_d, dv_q, dv_d;
    logic              dneg_q_q, dneg_q_d, dneg_r_q, dneg_r_d, drem_q, drem_d, dzero_q, dzero_d;

    logic              accept, is_mul, is_div, alu_valid, alu_jump;
    logic [XLEN-1:0]   alu_res, alu_tgt, jalr_sum, mul_res;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic [SH_W-1:0]   sh_r, sh_i;
    logic              div_sgn, a_neg, b_neg;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next, quot_next, quot_fix, rem_fix;

    assign in_ready   = rdy_in && !flush_in &&
                        (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_result = res_q;
    assign out_target_pc = tgt_q;
    assign out_jump   = jump_q;
    assign out_illegal = ill_q;
    assign out_tag    = tag_q;

    assign is_mul = inst_name inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div = inst_name inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    // Single-cycle ALU, branch compare and target generation
    always_comb begin
        alu_res   = '0;
        alu_tgt   = '0;
        alu_jump  = 1'b0;
        alu_valid = 1'b1;
        sh_r      = V2[SH_W-1:0];
        sh_i      = imm[SH_W-1:0];
        jalr_sum  = V1 + imm;
        case (inst_name)
            OP_LUI:   alu_res = imm;
            OP_AUIPC: alu_res = pc + imm;
            OP_JAL:   begin alu_tgt = pc + imm; alu_res = pc + XLEN'(4); alu_jump = 1'b1; end
            OP_JALR:  begin alu_tgt = {jalr_sum[XLEN-1:1], 1'b0}; alu_res = pc + XLEN'(4); alu_jump = 1'b1; end
            OP_BEQ:   alu_jump = (V1 == V2);
            OP_BNE:   alu_jump = (V1 != V2);
            OP_BLT:   alu_jump = ($signed(V1) < $signed(V2));
            OP_BGE:   alu_jump = ($signed(V1) >= $signed(V2));
            OP_BLTU:  alu_jump = (V1 < V2);
            OP_BGEU:  alu_jump = (V1 >= V2);
            OP_ADDI:  alu_res = V1 + imm;
            OP_SLTI:  alu_res = XLEN'($signed(V1) < $signed(imm));
            OP_SLTIU: alu_res = XLEN'(V1 < imm);
            OP_XORI:  alu_res = V1 ^ imm;
            OP_ORI:   alu_res = V1 | imm;
            OP_ANDI:  alu_res = V1 & imm;
            OP_SLLI:  alu_res = V1 << sh_i;
            OP_SRLI:  alu_res = V1 >> sh_i;
            OP_SRAI:  alu_res = $signed(V1) >>> sh_i;
            OP_ADD:   alu_res = V1 + V2;
            OP_SUB:   alu_res = V1 - V2;
            OP_SLL:   alu_res = V1 << sh_r;
            OP_SLT:   alu_res = XLEN'($signed(V1) < $signed(V2));
            OP_SLTU:  alu_res = XLEN'(V1 < V2);
            OP_XOR:   alu_res = V1 ^ V2;
            OP_SRL:   alu_res = V1 >> sh_r;
            OP_SRA:   alu_res = $signed(V1) >>> sh_r;
            OP_OR:    alu_res = V1 | V2;
            OP_AND:   alu_res = V1 & V2;
            default:  alu_valid = 1'b0;
        endcase
        if (inst_name inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
            alu_tgt = pc + imm;
            alu_res = XLEN'(alu_jump);
        end
    end

    // Full-width product; sign extension to 2*XLEN makes one multiplier cover all MUL variants
    always_comb begin
        mul_a    = {{XLEN{V1[XLEN-1] & (inst_name == OP_MULH || inst_name == OP_MULHSU)}}, V1};
        mul_b    = {{XLEN{V2[XLEN-1] & (inst_name == OP_MULH)}}, V2};
        mul_prod = mul_a * mul_b;
        mul_res  = (inst_name == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Divider operand preparation and one restoring step on unsigned magnitudes
    always_comb begin
        div_sgn   = (inst_name == OP_DIV || inst_name == OP_REM);
        a_neg     = div_sgn & V1[XLEN-1];
        b_neg     = div_sgn & V2[XLEN-1];
        rem_shift = {dr_q, dq_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dv_q};
        q_bit     = !rem_diff[XLEN];
        rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next = {dq_q[XLEN-2:0], q_bit};
        quot_fix  = dzero_q ? '1 : (dneg_q_q ? -quot_next : quot_next);
        rem_fix   = dzero_q ? dd_q : (dneg_r_q ? -rem_next : rem_next);
    end

    // Next-state: flush beats everything, rdy_in low freezes, accept overrides retire
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;
        res_d = res_q;  tgt_d = tgt_q;  jump_d = jump_q;  ill_d = ill_q;  tag_d = tag_q;
        dq_d = dq_q;  dr_d = dr_q;  dd_d = dd_q;  dv_d = dv_q;
        dneg_q_d = dneg_q_q;  dneg_r_d = dneg_r_q;  drem_d = drem_q;  dzero_d = dzero_q;
        if (flush_in) begin
            state_d = ST_IDLE;
        end else if (rdy_in) begin
            case (state_q)
                ST_MUL: begin
                    if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_DIV: begin
                    dq_d = quot_next;
                    dr_d = rem_next;
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        res_d   = drem_q ? rem_fix : quot_fix;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: ;
            endcase
            if (accept) begin
                if ((is_mul || is_div) && !M_ON) begin
                    state_d = ST_DONE;  res_d = '0;  tgt_d = '0;
                    jump_d = 1'b0;  ill_d = 1'b1;  tag_d = in_tag;
                end else if (is_mul) begin
                    state_d = (MUL_LAT <= 1) ? ST_DONE : ST_MUL;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    res_d = mul_res;  tgt_d = '0;  jump_d = 1'b0;  ill_d = 1'b0;  tag_d = in_tag;
                end else if (is_div) begin
                    state_d  = ST_DIV;
                    cnt_d    = CNT_W'(XLEN - 1);
                    dq_d     = a_neg ? -V1 : V1;
                    dv_d     = b_neg ? -V2 : V2;
                    dr_d     = '0;
                    dd_d     = V1;
                    dneg_q_d = a_neg ^ b_neg;
                    dneg_r_d = a_neg;
                    drem_d   = (inst_name == OP_REM || inst_name == OP_REMU);
                    dzero_d  = (V2 == '0);
                    tgt_d = '0;  jump_d = 1'b0;  ill_d = 1'b0;  tag_d = in_tag;
                end else if (alu_valid) begin
                    state_d = ST_DONE;  res_d = alu_res;  tgt_d = alu_tgt;
                    jump_d = alu_jump;  ill_d = 1'b0;  tag_d = in_tag;
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;  cnt_q <= '0;
            res_q <= '0;  tgt_q <= '0;  jump_q <= 1'b0;  ill_q <= 1'b0;  tag_q <= '0;
            dq_q <= '0;  dr_q <= '0;  dd_q <= '0;  dv_q <= '0;
            dneg_q_q <= 1'b0;  dneg_r_q <= 1'b0;  drem_q <= 1'b0;  dzero_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            res_q <= res_d;  tgt_q <= tgt_d;  jump_q <= jump_d;  ill_q <= ill_d;  tag_q <= tag_d;
            dq_q <= dq_d;  dr_q <= dr_d;  dd_q <= dd_d;  dv_q <= dv_d;
            dneg_q_q <= dneg_q_d;  dneg_r_q <= dneg_r_d;  drem_q <= drem_d;  dzero_q <= dzero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    localparam logic [5:0] OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3;
    localparam logic [5:0] OP_JALR = 6'd4, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9;
    localparam logic [5:0] OP_SLTI = 6'd12, OP_SRLI = 6'd18, OP_ADD = 6'd20, OP_SUB = 6'd21;
    localparam logic [5:0] OP_SLL = 6'd22, OP_SLTU = 6'd24, OP_SRA = 6'd27;
    localparam logic [5:0] OP_MUL = 6'd30, OP_MULH = 6'd31, OP_MULHSU = 6'd32, OP_MULHU = 6'd33;
    localparam logic [5:0] OP_DIV = 6'd34, OP_DIVU = 6'd35, OP_REM = 6'd36, OP_REMU = 6'd37;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic        in_valid = 1'b0, nm_in_valid = 1'b0, out_ready = 1'b1;
    logic [5:0]  inst_name = '0;
    logic [31:0] V1 = '0, V2 = '0, imm = '0, pc = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, out_jump, out_illegal, busy;
    logic [31:0] out_result, out_target_pc;
    logic [3:0]  out_tag;
    logic        nm_in_ready, nm_out_valid, nm_out_jump, nm_out_illegal, nm_busy;
    logic [31:0] nm_out_result, nm_out_target_pc;
    logic [3:0]  nm_out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.XLEN(32), .TAG_W(4), .ENABLE_M(1), .MUL_LAT(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .inst_name(inst_name),
        .V1(V1), .V2(V2), .imm(imm), .pc(pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_target_pc(out_target_pc), .out_jump(out_jump), .out_illegal(out_illegal),
        .out_tag(out_tag), .busy(busy));

    alu_exec_unit #(.XLEN(32), .TAG_W(4), .ENABLE_M(0), .MUL_LAT(2)) u_dut_nm (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(nm_in_valid), .in_ready(nm_in_ready), .inst_name(inst_name),
        .V1(V1), .V2(V2), .imm(imm), .pc(pc), .in_tag(in_tag),
        .out_valid(nm_out_valid), .out_ready(out_ready), .out_result(nm_out_result),
        .out_target_pc(nm_out_target_pc), .out_jump(nm_out_jump), .out_illegal(nm_out_illegal),
        .out_tag(nm_out_tag), .busy(nm_busy));

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, b, im, p, input logic [3:0] tag);
        inst_name = op; V1 = a; V2 = b; imm = im; pc = p; in_tag = tag;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, b, im, p, input logic [3:0] tag);
        drive(op, a, b, im, p, tag);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if ({out_result, out_target_pc, out_tag, out_jump, out_illegal} !== 70'd0) begin
            n_fail++; $display("FAIL reset_outputs res=%h tgt=%h tag=%h j=%b ill=%b exp all 0",
                               out_result, out_target_pc, out_tag, out_jump, out_illegal); end
        rst_in = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    logic [5:0]  alu_op  [9] = '{OP_ADD, OP_SRA, OP_SUB, OP_SLTU, OP_SLTI, OP_LUI, OP_AUIPC, OP_SRLI, OP_SLL};
    logic [31:0] alu_v1  [9] = '{32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd1, 32'd5, 32'd0, 32'd0, 32'h80000000, 32'd1};
    logic [31:0] alu_v2  [9] = '{32'd1, 32'h21, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'h24};
    logic [31:0] alu_imm [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h12345000, 32'h2000, 32'd4, 32'd0};
    logic [31:0] alu_pc  [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1000, 32'd0, 32'd0};
    logic [31:0] alu_exp [9] = '{32'h80000000, 32'hC0000000, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h12345000,
                                 32'h3000, 32'h08000000, 32'h10};

    task automatic test_alu();
        for (int i = 0; i < 9; i++) begin
            issue(alu_op[i], alu_v1[i], alu_v2[i], alu_imm[i], alu_pc[i], 4'(i + 3));
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid[%0d] got=%b exp=1", i, out_valid); end
            n_tests++; if (out_result !== alu_exp[i]) begin n_fail++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, out_result, alu_exp[i]); end
            n_tests++; if (out_tag !== 4'(i + 3)) begin n_fail++; $display("FAIL alu_tag[%0d] got=%h exp=%h", i, out_tag, 4'(i + 3)); end
            tick();
        end
    endtask

    logic [5:0]  ctl_op  [5] = '{OP_JALR, OP_BLTU, OP_BLT, OP_JAL, OP_BGE};
    logic [31:0] ctl_v1  [5] = '{32'h203, 32'd1, 32'd1, 32'd0, 32'd5};
    logic [31:0] ctl_v2  [5] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd5};
    logic [31:0] ctl_imm [5] = '{32'd0, 32'h10, 32'h10, 32'hFFFFFFF0, 32'h8};
    logic [31:0] ctl_pc  [5] = '{32'h100, 32'h200, 32'h200, 32'h400, 32'h300};
    logic [31:0] ctl_res [5] = '{32'h104, 32'd1, 32'd0, 32'h404, 32'd1};
    logic [31:0] ctl_tgt [5] = '{32'h202, 32'h210, 32'h210, 32'h3F0, 32'h308};
    logic        ctl_jmp [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic test_control();
        for (int i = 0; i < 5; i++) begin
            issue(ctl_op[i], ctl_v1[i], ctl_v2[i], ctl_imm[i], ctl_pc[i], 4'd1);
            n_tests++; if (out_result !== ctl_res[i]) begin n_fail++; $display("FAIL ctl_result[%0d] got=%h exp=%h", i, out_result, ctl_res[i]); end
            n_tests++; if (out_target_pc !== ctl_tgt[i]) begin n_fail++; $display("FAIL ctl_target[%0d] got=%h exp=%h", i, out_target_pc, ctl_tgt[i]); end
            n_tests++; if (out_jump !== ctl_jmp[i]) begin n_fail++; $display("FAIL ctl_jump[%0d] got=%b exp=%b", i, out_jump, ctl_jmp[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(OP_ADD, 32'd10, 32'd20, 32'd0, 32'd0, 4'd5);
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
            n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h1E || out_tag !== 4'd5) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b r=%h t=%h exp v=1 r=1e t=5", k, out_valid, out_result, out_tag); end
            tick();
        end
        drive(OP_SUB, 32'd9, 32'd4, 32'd0, 32'd0, 4'd6);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_tag !== 4'd6) begin
            n_fail++; $display("FAIL bp_sub got v=%b r=%h t=%h exp v=1 r=5 t=6", out_valid, out_result, out_tag); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_retired got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        in_valid = 1'b1;
        tick();
        for (int k = 2; k <= 4; k++) begin
            drive(OP_ADD, 32'(k), 32'(k), 32'd0, 32'd0, 4'(k));
            n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== 32'(2 * (k - 1))) begin
                n_fail++; $display("FAIL b2b[%0d] got v=%b rdy=%b r=%h exp v=1 rdy=1 r=%h", k, out_valid, in_ready, out_result, 32'(2 * (k - 1))); end
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (out_result !== 32'd8) begin n_fail++; $display("FAIL b2b_last got=%h exp=8", out_result); end
        tick();
    endtask

    logic [5:0]  md_op  [11] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU,
                                 OP_MULHU, OP_MUL, OP_MULH, OP_MULHSU};
    logic [31:0] md_v1  [11] = '{32'h80000000, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100,
                                 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] md_v2  [11] = '{32'hFFFFFFFF, 32'd0, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd7,
                                 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] md_exp [11] = '{32'h80000000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd14,
                                 32'hFFFFFFFE, 32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF};
    int          md_lat [11] = '{32, 32, 32, 32, 32, 32, 32, 1, 1, 1, 1};

    task automatic test_muldiv();
        int n;
        for (int i = 0; i < 11; i++) begin
            issue(md_op[i], md_v1[i], md_v2[i], 32'd0, 32'd0, 4'd7);
            if (i == 0) begin
                n_tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL div_busy got busy=%b v=%b exp busy=1 v=0", busy, out_valid); end
            end
            wait_valid(40, n);
            n_tests++; if (n !== md_lat[i]) begin n_fail++; $display("FAIL md_latency[%0d] got=%0d exp=%0d extra cycles", i, n, md_lat[i]); end
            n_tests++; if (out_result !== md_exp[i] || out_illegal !== 1'b0 || out_tag !== 4'd7) begin
                n_fail++; $display("FAIL md_result[%0d] got r=%h ill=%b t=%h exp r=%h ill=0 t=7", i, out_result, out_illegal, out_tag, md_exp[i]); end
            tick();
        end
    endtask

    task automatic test_flush();
        int n;
        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 4'd2);
        repeat (8) tick();
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);
        flush_in = 1'b1; in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        flush_in = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle got v=%b busy=%b exp v=0 busy=0", out_valid, busy); end
        wait_valid(40, n);
        n_tests++; if (n !== 40) begin n_fail++; $display("FAIL flush_no_result got valid after %0d cycles exp none", n); end
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);
        n_tests++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_tag !== 4'd9) begin
            n_fail++; $display("FAIL flush_after_add got v=%b r=%h t=%h exp v=1 r=2 t=9", out_valid, out_result, out_tag); end
        tick();
        out_ready = 1'b0;
        issue(OP_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd4);
        flush_in = 1'b1; out_ready = 1'b1;
        tick();
        flush_in = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_rdy();
        drive(OP_ADD, 32'd4, 32'd5, 32'd0, 32'd0, 4'd3);
        rdy_in = 1'b0; in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_in_ready got=%b exp=0", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rdy_frozen_idle got v=%b busy=%b exp 0 0", out_valid, busy); end
        rdy_in = 1'b1;
        tick();
        in_valid = 1'b0; rdy_in = 1'b0;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b1 || out_result !== 32'd9) begin
            n_fail++; $display("FAIL rdy_no_retire got v=%b r=%h exp v=1 r=9", out_valid, out_result); end
        rdy_in = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_retire got=%b exp=0", out_valid); end
    endtask

    task automatic test_nop();
        issue(OP_NOP, 32'd1, 32'd2, 32'd3, 32'd4, 4'd1);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL nop got v=%b busy=%b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_no_m();
        drive(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd0, 4'd8);
        nm_in_valid = 1'b1;
        #1;
        n_tests++; if (nm_in_ready !== 1'b1) begin n_fail++; $display("FAIL nm_in_ready got=%b exp=1", nm_in_ready); end
        tick();
        nm_in_valid = 1'b0;
        n_tests++; if (nm_out_valid !== 1'b1 || nm_out_illegal !== 1'b1 || nm_out_result !== 32'd0 ||
                       nm_out_jump !== 1'b0 || nm_out_tag !== 4'd8) begin
            n_fail++; $display("FAIL nm_mul got v=%b ill=%b r=%h j=%b t=%h exp v=1 ill=1 r=0 j=0 t=8",
                               nm_out_valid, nm_out_illegal, nm_out_result, nm_out_jump, nm_out_tag); end
        tick();
        n_tests++; if (nm_out_valid !== 1'b0) begin n_fail++; $display("FAIL nm_retire got=%b exp=0", nm_out_valid); end
    endtask

    task automatic test_async_reset();
        int n;
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd6);
        tick();
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 4'd6);
        repeat (4) tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got=%b exp=1", busy); end
        #3 rst_in = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'd0 || out_tag !== 4'd0) begin
            n_fail++; $display("FAIL arst_outputs got v=%b busy=%b r=%h t=%h exp all 0", out_valid, busy, out_result, out_tag); end
        #2 rst_in = 1'b0;
        wait_valid(40, n);
        n_tests++; if (n !== 40) begin n_fail++; $display("FAIL arst_no_result got valid after %0d cycles exp none", n); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_control();
        test_backpressure();
        test_back_to_back();
        test_muldiv();
        test_flush();
        test_rdy();
        test_nop();
        test_no_m();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered, handshaked integer execution unit for the Tomasulo back end. Sits between the RS issue port and the CDB arbiter, replacing the purely combinational ALU.
- Generalised in data width and ROB tag width.
- Adds an optional M-extension: a latency-configurable multiplier and an iterative radix-2 divider.
- Supports output back-pressure and misprediction flush.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
TAG_W, 4, ROB tag width
ENABLE_M, 1, 1 = implement MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = these opcodes flagged illegal
MUL_LAT, 2, cycles from acceptance of a multiply to out_valid (>=1)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
flush_in  input  1  ROB rollback; discard everything in flight
in_valid  input  1  RS presents an instruction
in_ready  output  1  unit accepts this cycle
inst_name  input  6  opcode code from defines (RV32I ALU/branch/jump set plus M codes)
V1  input  XLEN  rs1 value
V2  input  XLEN  rs2 value
imm  input  XLEN  sign-extended immediate
pc  input  XLEN  instruction PC
in_tag  input  TAG_W  ROB tag
out_valid  output  1  result held for CDB
out_ready  input  1  CDB grant
out_result  output  XLEN  rd value; branches give jump as 0/1
out_target_pc  output  XLEN  jump/branch target
out_jump  output  1  control transfer taken
out_illegal  output  1  M op with ENABLE_M=0
out_tag  output  TAG_W  ROB tag of result
busy  output  1  state != IDLE

Behaviour:
- Reset values: out_valid=0, out_jump=0, out_illegal=0, out_result=0, out_target_pc=0, out_tag=0, busy=0, state=IDLE.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = rdy_in && !flush_in && (state==IDLE || (state==DONE && out_ready)).
  - Output retires when out_valid && out_ready.
  - While out_valid=1, all out_* fields are held stable until retired.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept of a simple op -> DONE. Result is registered, so out_valid rises the next cycle (latency 1).
  - IDLE + accept of MUL* -> MUL, with a counter loaded to MUL_LAT-1. Goes to DONE when the counter reaches 0, then out_valid. Total latency is MUL_LAT. With MUL_LAT=1 the op goes straight to DONE.
  - IDLE + accept of DIV*/REM* -> DIV. Takes XLEN iterations, then DONE, so latency is XLEN+1. Operands are converted to magnitudes at accept and the sign is fixed in the final step.
  - DONE + out_ready -> IDLE. If a new op is accepted in the same cycle, go to that op's entry state instead. This gives back-to-back throughput of 1 for simple ops.
- Accepted NOP: consumed with no output, state stays IDLE.
- Semantics:
  - LUI = imm.
  - AUIPC = pc+imm.
  - JAL: target = pc+imm, result = pc+4, jump = 1.
  - JALR: target = (V1+imm) with bit0 cleared, result = pc+4, jump = 1.
  - Branches: target = pc+imm; jump is per the compare (signed/unsigned as named); result = jump.
  - Shifts use only the low log2(XLEN) bits of V2/imm. SRA/SRAI are arithmetic (signed).
  - SLT/SLTU/SLTI/SLTIU produce 0/1.
  - All arithmetic wraps modulo 2^XLEN.
- M extension rules (RISC-V):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - MULH* return the upper XLEN bits of the 2*XLEN product.
- ENABLE_M=0: M ops complete in 1 cycle with result 0, out_illegal=1, jump=0.
- flush_in:
  - Synchronous effect with highest priority.
  - The next state is IDLE, out_valid=0, and divider/multiplier progress is abandoned.
  - An input offered in the flush cycle is not accepted (in_ready=0).
  - A result that is valid in the flush cycle is dropped, even if out_ready=1.
- rdy_in=0: no state, counter, or output change; in_ready=0. out_valid keeps its value, but no retire happens.
- Asynchronous reset mid-divide or mid-multiply: immediately returns to the reset values; no partial result is ever emitted.

Test Plan:
- ADD V1=0x7FFFFFFF, V2=1, tag 3 -> next cycle out_valid=1, result 0x80000000, tag 3. SRA V1=0x80000000, V2=0x21 -> result 0xC0000000 (shift 1).
- JALR pc=0x100, V1=0x203, imm=0 -> target 0x202, result 0x104, jump=1. BLTU V1=1, V2=0xFFFFFFFF -> jump=1, result 1.
- Hold out_ready=0 for 5 cycles after ADD -> in_ready=0 and outputs stable. Raise out_ready with a new SUB offered -> both retire and accept that cycle; SUB is valid the next cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 33 cycles. REMU 7/0 -> 7. DIV -7/2 -> -3. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after MUL_LAT.
- Flush in cycle 10 of a DIV, with in_valid offered in the same cycle -> next cycle IDLE, out_valid=0, input not accepted. A following ADD behaves normally.
- ENABLE_M=0 with MUL -> 1 cycle, out_illegal=1, result 0. Async reset asserted mid-DIV -> all outputs 0 immediately.
